// File: rtl/alu_sequencer.sv
// Four-phase instruction sequencer: reads two operands from a local register file,
// presents them to an external combinational ALU and writes the result back.
module alu_sequencer #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned SEL_OPERATION  = 3,
    parameter int unsigned REG_ADDR_WIDTH = 3
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n_i,
    input  logic [SEL_OPERATION+3*REG_ADDR_WIDTH-1:0] instr_i,
    input  logic                                      instr_valid_i,
    output logic                                      instr_ready_o,
    input  logic                                      wr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0]                 wr_addr_i,
    input  logic [DATA_WIDTH-1:0]                     wr_data_i,
    input  logic [REG_ADDR_WIDTH-1:0]                 rd_addr_i,
    output logic [DATA_WIDTH-1:0]                     rd_data_o,
    output logic [DATA_WIDTH-1:0]                     alu_dataa_o,
    output logic [DATA_WIDTH-1:0]                     alu_datab_o,
    output logic [SEL_OPERATION-1:0]                  alu_sel_o,
    input  logic [DATA_WIDTH-1:0]                     alu_result_i,
    output logic [DATA_WIDTH-1:0]                     result_o,
    output logic                                      done_o
);

    localparam int unsigned INSTR_W  = SEL_OPERATION + 3 * REG_ADDR_WIDTH;
    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [INSTR_W-1:0]        instr_q, instr_d;
    logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]     regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0]     dataa_q, dataa_d;
    logic [DATA_WIDTH-1:0]     datab_q, datab_d;
    logic [SEL_OPERATION-1:0]  sel_q, sel_d;
    logic [DATA_WIDTH-1:0]     result_q, result_d;
    logic                      done_q, done_d;

    logic                      accept_c;
    logic [SEL_OPERATION-1:0]  op_c;
    logic [REG_ADDR_WIDTH-1:0] rd_c, ra_c, rb_c;

    assign op_c = instr_q[INSTR_W-1 -: SEL_OPERATION];
    assign rd_c = instr_q[3*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
    assign ra_c = instr_q[2*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
    assign rb_c = instr_q[REG_ADDR_WIDTH-1:0];

    assign accept_c = instr_valid_i && (state_q == ST_IDLE);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only IDLE waits, the other phases advance every cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath logic; a host write in IDLE lands before the operand read of
    // an instruction accepted on the same edge
    always_comb begin
        instr_d  = instr_q;
        regs_d   = regs_q;
        dataa_d  = dataa_q;
        datab_d  = datab_q;
        sel_d    = sel_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) instr_d = instr_i;
                if (wr_en_i)  regs_d[wr_addr_i] = wr_data_i;
            end
            ST_READ: begin
                dataa_d = regs_q[ra_c];
                datab_d = regs_q[rb_c];
                sel_d   = op_c;
            end
            ST_EXEC: begin
                regs_d[rd_c] = alu_result_i;
                result_d     = alu_result_i;
                done_d       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instr_q  <= '0;
            dataa_q  <= '0;
            datab_q  <= '0;
            sel_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            instr_q  <= instr_d;
            dataa_q  <= dataa_d;
            datab_q  <= datab_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            done_q   <= done_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign instr_ready_o = (state_q == ST_IDLE);
    assign rd_data_o     = regs_q[rd_addr_i];
    assign alu_dataa_o   = dataa_q;
    assign alu_datab_o   = datab_q;
    assign alu_sel_o     = sel_q;
    assign result_o      = result_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a register-file model predicts every write-back,
// a negedge monitor checks each done_o pulse and the ready handshake.
module tb_alu_sequencer;

    localparam int DW = 16;
    localparam int SW = 3;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [SW+3*AW-1:0] instr_i;
    logic            instr_valid_i;
    logic            instr_ready_o;
    logic            wr_en_i;
    logic [AW-1:0]   wr_addr_i;
    logic [DW-1:0]   wr_data_i;
    logic [AW-1:0]   rd_addr_i;
    logic [DW-1:0]   rd_data_o;
    logic [DW-1:0]   alu_a, alu_b, alu_res, result_o;
    logic [SW-1:0]   alu_sel;
    logic            done_o;

    alu_sequencer #(.DATA_WIDTH(DW), .SEL_OPERATION(SW), .REG_ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .instr_i(instr_i), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .alu_dataa_o(alu_a), .alu_datab_o(alu_b), .alu_sel_o(alu_sel),
        .alu_result_i(alu_res), .result_o(result_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Ops: 0 sum, 1 sub, 2 not, 3 and, 4 or, 5 xor, 6 sll, 7 srl
    function automatic logic [DW-1:0] alu_fn(input logic [SW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return ~a;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return a << b;
            default: return a >> b;
        endcase
    endfunction

    always_comb alu_res = alu_fn(alu_sel, alu_a, alu_b);

    typedef struct {
        logic [DW-1:0] res;
        logic [AW-1:0] rd;
        int            done_cyc;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] m [8];
    int cyc       = 0;
    int busy_from = -10;
    int busy_to   = -10;
    int last_acc  = -100;
    int n_cmp     = 0;
    int n_err     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: handshake every cycle, scoreboard pop on each done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", 32'(instr_ready_o), 32'(!(cyc >= busy_from && cyc <= busy_to)));
            if (sbq.size() > 0 && cyc > sbq[0].done_cyc) begin
                n_cmp++; n_err++;
                $display("FAIL done_missing: no done by cycle %0d expected for rd=%0d", sbq[0].done_cyc, sbq[0].rd);
                void'(sbq.pop_front());
            end
            if (done_o) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL done_unexpected: done_o=1 with no pending instruction at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("result", 32'(result_o), 32'(e.res));
                    chk("rd_data_wb", 32'(rd_data_o), 32'(e.res));
                    chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!instr_ready_o && t < 40) begin @(negedge clk); t++; end
        if (!instr_ready_o) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout: instr_ready_o stuck low at cycle %0d", cyc);
        end
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        instr_valid_i = 1'b0;
        wait_ready();
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        m[a] = d;
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    // Offers an instruction; optionally a same-edge host write and a held valid
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                         input bit hold, input bit do_wr, input logic [2:0] wa, input logic [DW-1:0] wd,
                         input bit chk_gap);
        logic [DW-1:0] e;
        instr_i = {op, rd, ra, rb};
        instr_valid_i = 1'b1;
        wait_ready();
        rd_addr_i = rd;
        if (do_wr) begin
            wr_en_i = 1'b1; wr_addr_i = wa; wr_data_i = wd;
            m[wa] = wd;
        end
        e = alu_fn(op, m[ra], m[rb]);
        m[rd] = e;
        sbq.push_back('{res: e, rd: rd, done_cyc: cyc + 3});
        busy_from = cyc + 1;
        busy_to   = cyc + 3;
        if (chk_gap) chk("accept_gap", 32'(cyc - last_acc), 32'd4);
        last_acc = cyc;
        @(negedge clk);
        wr_en_i = 1'b0;
        if (!hold) instr_valid_i = 1'b0;
    endtask

    // Called right after issue(); the write is offered on a non-IDLE edge and must be dropped
    task automatic busy_write(input int dly, input logic [AW-1:0] a, input logic [DW-1:0] d);
        for (int i = 0; i < dly; i++) @(negedge clk);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    task automatic check_reg(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        instr_valid_i = 1'b0;
        wait_ready();
        rd_addr_i = a;
        #1;
        chk($sformatf("reg_R%0d", a), 32'(rd_data_o), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        instr_i = '0; instr_valid_i = 1'b0;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; rd_addr_i = 3'd5;
        for (int i = 0; i < 8; i++) m[i] = '0;
        #1;
        chk("rst_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_result", 32'(result_o), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_rd_data", 32'(rd_data_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", 32'(instr_ready_o), 32'd1);
        @(negedge clk);

        // Simple sum
        host_write(3'd1, 16'h0005);
        host_write(3'd2, 16'h0003);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 0, 0, 0, 0, 0);
        check_reg(3'd3, 16'h0008);

        // Wrapping subtract and shift beyond width
        host_write(3'd1, 16'h0000);
        host_write(3'd2, 16'h0001);
        issue(3'd1, 3'd4, 3'd1, 3'd2, 0, 0, 0, 0, 0);
        check_reg(3'd4, 16'hFFFF);
        host_write(3'd6, 16'h0010);
        host_write(3'd1, 16'h0001);
        issue(3'd6, 3'd5, 3'd1, 3'd6, 0, 0, 0, 0, 0);
        check_reg(3'd5, 16'h0000);

        // Dependent back-to-back with valid held high
        host_write(3'd1, 16'h0005);
        host_write(3'd2, 16'h0003);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 1, 0, 0, 0, 0);
        issue(3'd5, 3'd4, 3'd3, 3'd1, 0, 0, 0, 0, 1);
        check_reg(3'd3, 16'h0008);
        check_reg(3'd4, 16'h000D);

        // Write during EXEC is dropped; same-edge write is seen by the operand read
        issue(3'd3, 3'd6, 3'd1, 3'd1, 0, 0, 0, 0, 0);
        busy_write(1, 3'd1, 16'h1234);
        check_reg(3'd1, 16'h0005);
        host_write(3'd0, 16'h0F00);
        issue(3'd4, 3'd7, 3'd2, 3'd0, 0, 1, 3'd2, 16'h00FF, 0);
        check_reg(3'd7, 16'h0FFF);
        check_reg(3'd2, 16'h00FF);

        // Reset in the middle of EXEC aborts the write-back
        issue(3'd0, 3'd3, 3'd7, 3'd2, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(instr_ready_o), 32'd1);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_alu_a", 32'(alu_a), 32'd0);
        chk("abort_alu_b", 32'(alu_b), 32'd0);
        chk("abort_sel", 32'(alu_sel), 32'd0);
        chk("abort_result", 32'(result_o), 32'd0);
        chk("abort_R3", 32'(rd_data_o), 32'd0);
        sbq.delete();
        busy_from = -10; busy_to = -10;
        for (int i = 0; i < 8; i++) m[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("abort_ready_release", 32'(instr_ready_o), 32'd1);
        @(negedge clk);
        chk("abort_no_done", 32'(done_o), 32'd0);
        check_reg(3'd3, 16'h0000);
        check_reg(3'd7, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic [DW-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 20)) : DW'($urandom);
            if ($urandom_range(0, 9) < 3) begin
                host_write(AW'($urandom_range(0, 7)), d);
            end else begin
                issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), d, 0);
                if ($urandom_range(0, 9) < 3)
                    busy_write($urandom_range(0, 2), AW'($urandom_range(0, 7)), DW'($urandom));
            end
        end

        for (int i = 0; i < 8; i++) check_reg(AW'(i), m[i]);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d results never reported", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
